// File: rtl/rotate_align_ctrl.sv
// rotate_align_ctrl
//
// Word-alignment controller that sits directly in front of a rotate-right
// barrel shifter. Every incoming word is compared against the framing
// pattern at every rotation. A hunt/verify/lock state machine picks the
// rotation and confirms it over several frames. The word is then passed on,
// registered, together with the rotate distance the shifter must apply to it.
//
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   din         in   [WIDTH]       unaligned input word
//   din_valid   in   din qualifier
//   dout        out  [WIDTH]       registered din, feeds the shifter data input
//   dout_valid  out  dout qualifier
//   distance    out  [DIST_WIDTH]  rotate-right distance for the current dout
//   locked      out  alignment locked
//   sof         out  dout is frame word 0 (only while locked)
//   slip_count  out  [16]          LOCKED->HUNT count, saturating
//                                  (present only with ROTATE_ALIGN_STATS_EN)
//
// Optional feature macro: ROTATE_ALIGN_STATS_EN

module rotate_align_ctrl #(
    parameter int                WIDTH        = 16,
    parameter int                DIST_WIDTH   = 4,
    parameter logic [WIDTH-1:0]  PATTERN      = 16'hF628,
    parameter int                FRAME_LEN    = 8,
    parameter int                LOCK_COUNT   = 4,
    parameter int                UNLOCK_COUNT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WIDTH-1:0]      din,
    input  logic                  din_valid,
    output logic [WIDTH-1:0]      dout,
    output logic                  dout_valid,
    output logic [DIST_WIDTH-1:0] distance,
    output logic                  locked,
    output logic                  sof
`ifdef ROTATE_ALIGN_STATS_EN
    ,
    output logic [15:0]           slip_count
`endif
);

    localparam int WC_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [WC_W-1:0] WC_LAST  = WC_W'(FRAME_LEN - 1);
    localparam logic [WC_W-1:0] WC_FIRST = WC_W'(1 % FRAME_LEN);
    localparam logic [4:0]      LOCK_THR   = 5'(LOCK_COUNT);
    localparam logic [4:0]      UNLOCK_THR = 5'(UNLOCK_COUNT);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [WC_W-1:0]       word_cnt_q, word_cnt_d, word_inc;
    logic [3:0]            good_cnt_q, good_cnt_d;
    logic [3:0]            miss_cnt_q, miss_cnt_d;
    logic [DIST_WIDTH-1:0] distance_d;
    logic                  sof_d;
    logic                  any_hit;
    logic [DIST_WIDTH-1:0] win_d;
    logic                  hit_at_dist;
    logic [4:0]            good_next, miss_next;

    function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] x, input int d);
        logic [2*WIDTH-1:0] dbl;
        dbl = {x, x} >> d;
        return dbl[WIDTH-1:0];
    endfunction

    // Search every rotation for the pattern. The loop runs from the highest
    // rotation down, so the lowest matching rotation is the one left in win_d.
    always_comb begin
        any_hit = 1'b0;
        win_d   = '0;
        for (int d = WIDTH - 1; d >= 0; d--) begin
            if (rotr(din, d) == PATTERN) begin
                any_hit = 1'b1;
                win_d   = DIST_WIDTH'(d);
            end
        end
    end

    // Check whether the word matches at the rotation already chosen. This is
    // used only while verifying or locked. Distances at or beyond WIDTH never match.
    always_comb begin
        hit_at_dist = 1'b0;
        for (int d = 0; d < WIDTH; d++) begin
            if ((DIST_WIDTH'(d) == distance) && (rotr(din, d) == PATTERN)) begin
                hit_at_dist = 1'b1;
            end
        end
    end

    // Next-state and counter logic. Nothing moves unless din_valid is high.
    // The frame-position counter is cleared on any return to HUNT, so the
    // next hunt starts clean.
    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        good_cnt_d = good_cnt_q;
        miss_cnt_d = miss_cnt_q;
        distance_d = distance;
        sof_d      = 1'b0;
        word_inc   = (word_cnt_q == WC_LAST) ? '0 : word_cnt_q + 1'b1;
        good_next  = {1'b0, good_cnt_q} + 5'd1;
        miss_next  = {1'b0, miss_cnt_q} + 5'd1;
        if (din_valid) begin
            case (state_q)
                HUNT: begin
                    if (any_hit) begin
                        distance_d = win_d;
                        word_cnt_d = WC_FIRST;
                        good_cnt_d = 4'd1;
                        miss_cnt_d = 4'd0;
                        if (LOCK_COUNT == 1) begin
                            state_d = LOCKED;
                            sof_d   = 1'b1;
                        end else begin
                            state_d = VERIFY;
                        end
                    end
                end
                VERIFY: begin
                    word_cnt_d = word_inc;
                    if (word_cnt_q == '0) begin
                        if (hit_at_dist) begin
                            good_cnt_d = good_next[4] ? 4'hF : good_next[3:0];
                            if (good_next >= LOCK_THR) begin
                                state_d    = LOCKED;
                                miss_cnt_d = 4'd0;
                                sof_d      = 1'b1;
                            end
                        end else begin
                            state_d    = HUNT;
                            good_cnt_d = 4'd0;
                            word_cnt_d = '0;
                        end
                    end
                end
                LOCKED: begin
                    word_cnt_d = word_inc;
                    if (word_cnt_q == '0) begin
                        sof_d = 1'b1;
                        if (hit_at_dist) begin
                            miss_cnt_d = 4'd0;
                        end else if (miss_next >= UNLOCK_THR) begin
                            state_d    = HUNT;
                            miss_cnt_d = 4'd0;
                            word_cnt_d = '0;
                            sof_d      = 1'b0;
                        end else begin
                            miss_cnt_d = miss_next[4] ? 4'hF : miss_next[3:0];
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end
    end

    // State, counters and the output register stage. dout holds its value
    // across stalls, while dout_valid and sof drop for the stalled cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= HUNT;
            word_cnt_q <= '0;
            good_cnt_q <= '0;
            miss_cnt_q <= '0;
            distance   <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            sof        <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            good_cnt_q <= good_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            distance   <= distance_d;
            dout_valid <= din_valid;
            sof        <= sof_d;
            if (din_valid) begin
                dout <= din;
            end
        end
    end

    assign locked = (state_q == LOCKED);

`ifdef ROTATE_ALIGN_STATS_EN
    // Count loss-of-lock events; saturates instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slip_count <= '0;
        end else if ((state_q == LOCKED) && (state_d == HUNT) && (slip_count != 16'hFFFF)) begin
            slip_count <= slip_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rotate_align_ctrl.sv
// tb_rotate_align_ctrl
//
// Directed bench for rotate_align_ctrl with the default parameters
// (PATTERN 16'hF628, FRAME_LEN 8, LOCK_COUNT 4, UNLOCK_COUNT 4).
// A second instance with PATTERN 16'hAAAA exercises multi-match priority.
// The pattern words are hand-computed:
//   16'hC51E = rotate-left(16'hF628, 5)
//   16'h51EC = rotate-left(16'hF628, 9)
// Filler words are small values whose popcount is below 8, so no rotation
// of a filler word can equal either pattern.

module tb_rotate_align_ctrl;

    localparam logic [15:0] PAT_D5 = 16'hC51E;
    localparam logic [15:0] PAT_D9 = 16'h51EC;

    logic        clk;
    logic        rst_n;
    logic [15:0] din;
    logic        din_valid;
    logic [15:0] dout;
    logic        dout_valid;
    logic [3:0]  distance;
    logic        locked;
    logic        sof;
    logic [15:0] mm_dout;
    logic        mm_dout_valid;
    logic [3:0]  mm_distance;
    logic        mm_locked;
    logic        mm_sof;
`ifdef ROTATE_ALIGN_STATS_EN
    logic [15:0] slip_count;
    logic [15:0] mm_slip_count;
`endif

    int checks = 0;
    int errors = 0;
    int fill_seed = 1;
    logic [15:0] last_fill;

    rotate_align_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .dout       (dout),
        .dout_valid (dout_valid),
        .distance   (distance),
        .locked     (locked),
        .sof        (sof)
`ifdef ROTATE_ALIGN_STATS_EN
        ,
        .slip_count (slip_count)
`endif
    );

    rotate_align_ctrl #(.PATTERN(16'hAAAA)) dut_mm (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .dout       (mm_dout),
        .dout_valid (mm_dout_valid),
        .distance   (mm_distance),
        .locked     (mm_locked),
        .sof        (mm_sof)
`ifdef ROTATE_ALIGN_STATS_EN
        ,
        .slip_count (mm_slip_count)
`endif
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value with its expected value and tally the result.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive one word on the falling edge. Outputs are then sampled 1 unit after
    // the rising edge, which is when they reflect this word.
    task automatic applyStimulus(input logic [15:0] word, input logic valid);
        @(negedge clk);
        din       = word;
        din_valid = valid;
        @(posedge clk);
        #1;
    endtask

    // Send n valid filler words that never match any rotation.
    task automatic sendFiller(input int n);
        for (int i = 0; i < n; i++) begin
            last_fill = 16'(fill_seed);
            fill_seed = (fill_seed % 100) + 1;
            applyStimulus(last_fill, 1'b1);
        end
    endtask

    // Directed sequence, covering reset, lock, stall, loss of lock,
    // verify failure and multi-match priority.
    initial begin
        rst_n     = 1'b0;
        din       = PAT_D5;
        din_valid = 1'b0;

        // Reset held low while din_valid toggles.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(PAT_D5, (i % 2) == 1);
            checkOutput("rst_dout_valid", 32'(dout_valid), 32'd0);
        end
        checkOutput("rst_dout", 32'(dout), 32'd0);
        checkOutput("rst_distance", 32'(distance), 32'd0);
        checkOutput("rst_locked", 32'(locked), 32'd0);
        checkOutput("rst_sof", 32'(sof), 32'd0);
        checkOutput("rst_mm_distance", 32'(mm_distance), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Hunting with filler only: nothing is loaded.
        sendFiller(2);
        checkOutput("hunt_fill_dout", 32'(dout), 32'(last_fill));
        checkOutput("hunt_fill_valid", 32'(dout_valid), 32'd1);
        checkOutput("hunt_fill_distance", 32'(distance), 32'd0);
        checkOutput("hunt_fill_locked", 32'(locked), 32'd0);

        // Four frames at d=5. Lock is declared with the fourth pattern.
        for (int f = 0; f < 4; f++) begin
            applyStimulus(PAT_D5, 1'b1);
            checkOutput("lock_dout", 32'(dout), 32'(PAT_D5));
            checkOutput("lock_distance", 32'(distance), 32'd5);
            checkOutput("lock_locked", 32'(locked), (f == 3) ? 32'd1 : 32'd0);
            checkOutput("lock_sof", 32'(sof), (f == 3) ? 32'd1 : 32'd0);
            sendFiller(7);
            checkOutput("lock_fill_sof", 32'(sof), 32'd0);
        end
        applyStimulus(PAT_D5, 1'b1);
        checkOutput("locked_sof", 32'(sof), 32'd1);
        checkOutput("locked_locked", 32'(locked), 32'd1);

        // Stall mid-frame for 5 cycles. The pattern on din is ignored while invalid.
        sendFiller(3);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(PAT_D5, 1'b0);
            checkOutput("stall_dout_valid", 32'(dout_valid), 32'd0);
            checkOutput("stall_dout_hold", 32'(dout), 32'(last_fill));
            checkOutput("stall_sof", 32'(sof), 32'd0);
        end
        sendFiller(4);
        checkOutput("stall_resume_sof", 32'(sof), 32'd0);
        applyStimulus(PAT_D5, 1'b1);
        checkOutput("stall_frame_sof", 32'(sof), 32'd1);
        checkOutput("stall_locked", 32'(locked), 32'd1);
        sendFiller(7);

        // Loss of lock: 3 misses, 1 good frame, then 4 misses.
        for (int m = 0; m < 3; m++) begin
            sendFiller(1);
            checkOutput("miss_a_locked", 32'(locked), 32'd1);
            checkOutput("miss_a_sof", 32'(sof), 32'd1);
            sendFiller(7);
        end
        applyStimulus(PAT_D5, 1'b1);
        checkOutput("regain_locked", 32'(locked), 32'd1);
        checkOutput("regain_sof", 32'(sof), 32'd1);
        sendFiller(7);
        for (int m = 0; m < 4; m++) begin
            sendFiller(1);
            checkOutput("miss_b_locked", 32'(locked), (m < 3) ? 32'd1 : 32'd0);
            checkOutput("miss_b_sof", 32'(sof), (m < 3) ? 32'd1 : 32'd0);
            checkOutput("miss_b_distance", 32'(distance), 32'd5);
            if (m < 3) begin
                sendFiller(7);
            end
        end
`ifdef ROTATE_ALIGN_STATS_EN
        checkOutput("slip_count", 32'(slip_count), 32'd1);
`endif

        // Verify failure: two good frames at d=5, then the frame start carries d=9.
        applyStimulus(PAT_D5, 1'b1);
        checkOutput("vfy_first_distance", 32'(distance), 32'd5);
        checkOutput("vfy_first_locked", 32'(locked), 32'd0);
        sendFiller(7);
        applyStimulus(PAT_D5, 1'b1);
        checkOutput("vfy_second_locked", 32'(locked), 32'd0);
        sendFiller(7);
        applyStimulus(PAT_D9, 1'b1);
        checkOutput("vfy_fail_distance", 32'(distance), 32'd5);
        checkOutput("vfy_fail_locked", 32'(locked), 32'd0);
        checkOutput("vfy_fail_sof", 32'(sof), 32'd0);
        applyStimulus(PAT_D9, 1'b1);
        checkOutput("vfy_rehunt_distance", 32'(distance), 32'd9);
        checkOutput("vfy_rehunt_locked", 32'(locked), 32'd0);

        // Multi-match: 16'h5555 matches 16'hAAAA at every odd rotation.
        checkOutput("mm_pre_distance", 32'(mm_distance), 32'd0);
        applyStimulus(16'h5555, 1'b1);
        checkOutput("mm_distance", 32'(mm_distance), 32'd1);
        checkOutput("mm_dout", 32'(mm_dout), 32'h5555);
        checkOutput("mm_locked", 32'(mm_locked), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rotate_align_ctrl.md
Name: rotate_align_ctrl

Overview:
- Word-alignment controller placed directly upstream of the rotate-right barrel shifter.
- Searches incoming words for a framing pattern at every rotation and runs a hunt/verify/lock state machine.
- Drives a registered data word plus a matching rotate distance, so the shifter emits frame-aligned words.
- Also provides lock status and a start-of-frame marker.

Parameters:
WIDTH, 16, data word width in bits
DIST_WIDTH, 4, rotate distance width; must satisfy 2**DIST_WIDTH >= WIDTH
PATTERN, 16'hF628, framing word expected once per frame after rotate-right by the correct distance
FRAME_LEN, 8, valid words per frame, 2..256; pattern occupies word 0
LOCK_COUNT, 4, consecutive good frames (including the first hit) required to declare lock, 1..15
UNLOCK_COUNT, 4, consecutive missed patterns that drop lock, 1..15

Ports:
clk  in  1  clock, all logic rising-edge
rst_n  in  1  asynchronous active-low reset
din  in  WIDTH  unaligned input word
din_valid  in  1  din qualifier
dout  out  WIDTH  din registered; feeds barrel shifter data input
dout_valid  out  1  dout qualifier
distance  out  DIST_WIDTH  rotate-right distance for the dout word currently presented
locked  out  1  alignment locked
sof  out  1  dout is frame word 0; only asserted while locked

Behaviour:
- Reset (asynchronous on rst_n low): dout=0, dout_valid=0, distance=0, locked=0, sof=0, state=HUNT, all counters 0.
- Reset mid-frame aborts everything; alignment restarts from HUNT.
- Match logic is combinational. hit[d]=1 when rotate-right(din,d)==PATTERN, for d in 0..WIDTH-1. d>=WIDTH never matches.
- When several d match (periodic pattern), the lowest d wins.
- Latency: one cycle. dout/dout_valid/distance/sof all update on the edge after din/din_valid.
  - distance always applies to the dout word it accompanies.
- din_valid=0: no state, counter, or distance change. dout_valid=0. dout holds its value.

State machine (advances only on din_valid=1):
- HUNT:
  - Any hit: distance <= winning d; word_cnt <= 1 (mod FRAME_LEN); good_cnt <= 1.
  - If LOCK_COUNT==1, go to LOCKED directly; else go to VERIFY.
  - No hit: stay; distance unchanged.
- VERIFY:
  - word_cnt increments mod FRAME_LEN on each valid word.
  - When word_cnt==0, check hit[distance]:
    - hit: good_cnt++; when good_cnt reaches LOCK_COUNT, go to LOCKED.
    - miss: go to HUNT, good_cnt=0; the same word is not re-searched.
  - Hits at other distances or other word positions are ignored.
- LOCKED:
  - locked=1 from the edge that enters LOCKED.
  - At word_cnt==0: hit clears miss_cnt; miss increments miss_cnt.
  - When miss_cnt reaches UNLOCK_COUNT, go to HUNT, locked=0 on that edge, miss_cnt=0.
  - distance is frozen throughout VERIFY and LOCKED.
- sof=1 with dout_valid when the registered word had word_cnt==0 in LOCKED, including the entry word.
- word_cnt wraps FRAME_LEN-1 -> 0. Counters saturate and never wrap.

Optional Feature:
ROTATE_ALIGN_STATS_EN
- Defined: adds output port slip_count (16 bits).
  - Increments on every LOCKED->HUNT transition and saturates at 16'hFFFF.
  - Cleared only by rst_n.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset then idle: rst_n low for 3 cycles with din_valid toggling -> all outputs 0, state HUNT; dout_valid stays 0 while rst_n low.
- Lock at d=5: din=rotate-left(16'hF628,5) every 8th valid word, random non-matching filler otherwise.
  - distance=5 on the first hit's dout cycle; locked rises with the 4th pattern's dout.
  - sof pulses on every pattern word from then on.
- Verify failure: 2 good patterns at d=5, third frame start carries the pattern at d=9 -> return to HUNT, locked stays 0.
  - The next hit at d=9 loads distance=9.
- Loss of lock: locked at d=5, corrupt 3 consecutive frame starts, then 1 good, then 4 bad.
  - locked stays 1 through the first 3 misses; drops on the 4th consecutive miss.
  - With ROTATE_ALIGN_STATS_EN, slip_count=1.
- Stall handling: locked, din_valid low for 5 cycles mid-frame -> word_cnt, sof position, and dout unchanged; dout_valid=0 during the stall.
- Multi-match priority: PATTERN=16'hAAAA with din=16'h5555 -> distance=1 (lowest of the odd matches).
